prop_delay_meter: RTL and testbench

Synthesizable propagation-delay meter: the measuring end of the cell-characterization loop. It watches the stimulus applied to a cell-under-test input and the cell's output, and timestamps the selected stimulus edge and the matching output edge. It returns the delay in clock cycles through a valid/ready result port. It sits beside the characterization board model, replacing the analog delay probe with a digital count, and is driven by a sweep controller that arms one measurement per slope/load point.

---
 rtl/pdm_pkg.sv | 18 +
 rtl/pdm_edge_det.sv | 49 ++++
 rtl/prop_delay_meter.sv | 135 +++++++++++++
 tb/tb_prop_delay_meter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and defaults for the propagation-delay meter.
// Optional build macro: PDM_SYNC_EN (2-flop input synchronizers in pdm_edge_det).
package pdm_pkg;

    localparam int unsigned PDM_CNT_W   = 16;
    localparam int unsigned PDM_TIMEOUT = 1000;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } pdm_state_e;

endpackage

// File: rtl/pdm_edge_det.sv
// Edge detector: optional 2-flop synchronizer (PDM_SYNC_EN) followed by a single history
// register; emits single-cycle rise/fall pulses.
module pdm_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_s;
    logic hist_q, hist_d;

`ifdef PDM_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], sig_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_i;
`endif

    always_comb begin
        hist_d = sig_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise_o = sig_s & ~hist_q;
    assign fall_o = ~sig_s & hist_q;

endmodule

// File: rtl/prop_delay_meter.sv
// Propagation-delay meter: timestamps a selected stimulus edge and the matching cell-output
// edge, returning the cycle delay over a valid/ready port. Optional macro: PDM_SYNC_EN.
module prop_delay_meter
    import pdm_pkg::*;
#(
    parameter int unsigned CNT_W     = PDM_CNT_W,
    parameter int unsigned TIMEOUT   = PDM_TIMEOUT,
    parameter bit          INVERTING = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_i,
    input  logic             edge_sel_i,
    input  logic             stim_i,
    input  logic             resp_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_delay_o,
    output logic             res_timeout_o
);

    localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    pdm_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] res_delay_q, res_delay_d;
    logic             res_timeout_q, res_timeout_d;

    logic stim_rise, stim_fall, resp_rise, resp_fall;
    logic stim_edge, resp_edge;

    pdm_edge_det u_stim_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (stim_i),
        .rise_o (stim_rise),
        .fall_o (stim_fall)
    );

    pdm_edge_det u_resp_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (resp_i),
        .rise_o (resp_rise),
        .fall_o (resp_fall)
    );

    assign stim_edge = (sel_q == EDGE_RISE) ? stim_rise : stim_fall;
    assign resp_edge = (exp_q == EDGE_RISE) ? resp_rise : resp_fall;

    // Saturating increment; the timeout check normally stops the count well before this.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        exp_d         = exp_q;
        cnt_d         = cnt_q;
        res_delay_d   = res_delay_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    sel_d   = edge_sel_i;
                    exp_d   = edge_sel_i ^ INVERTING;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (stim_edge) begin
                    cnt_d = '0;
                    if (resp_edge) begin
                        res_delay_d   = '0;
                        res_timeout_d = 1'b0;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                // cnt_q lags elapsed cycles by one, so cnt_inc is the delay including this cycle.
                if (resp_edge) begin
                    res_delay_d   = cnt_inc;
                    res_timeout_d = 1'b0;
                    state_d       = ST_DONE;
                end else if (cnt_inc >= TimeoutC) begin
                    res_delay_d   = TimeoutC;
                    res_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            exp_q         <= 1'b0;
            cnt_q         <= '0;
            res_delay_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            exp_q         <= exp_d;
            cnt_q         <= cnt_d;
            res_delay_q   <= res_delay_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign res_valid_o   = (state_q == ST_DONE);
    assign res_delay_o   = res_delay_q;
    assign res_timeout_o = res_timeout_q;

endmodule

// File: tb/tb_prop_delay_meter.sv
// Scoreboard bench for prop_delay_meter: randomized measurements checked against a
// behavioural model of expected delay / timeout, with a separate result monitor.
module tb_prop_delay_meter;

    localparam int CNT_W = 16;
    localparam int TMO   = 20;
    localparam bit INV   = 1'b1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             arm_i = 1'b0;
    logic             edge_sel_i = 1'b0;
    logic             stim_i = 1'b0;
    logic             resp_i = 1'b0;
    logic             res_ready_i = 1'b0;
    logic             busy_o;
    logic             res_valid_o;
    logic [CNT_W-1:0] res_delay_o;
    logic             res_timeout_o;

    typedef struct {
        int dly;
        int tmo;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ready_mode = 0;  // 0 random, 1 always high, 2 always low

    prop_delay_meter #(
        .CNT_W     (CNT_W),
        .TIMEOUT   (TMO),
        .INVERTING (INV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm_i         (arm_i),
        .edge_sel_i    (edge_sel_i),
        .stim_i        (stim_i),
        .resp_i        (resp_i),
        .busy_o        (busy_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_delay_o   (res_delay_o),
        .res_timeout_o (res_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       res_ready_i = ($urandom_range(0, 2) == 0);
                1:       res_ready_i = 1'b1;
                default: res_ready_i = 1'b0;
            endcase
        end
    end

    // Result monitor: pops the scoreboard on each handshake and checks hold/idle behaviour.
    initial begin
        bit   pv, pr, ph;
        int   pd, pt;
        res_t e;
        pv = 0; pr = 0; ph = 0; pd = 0; pt = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pv = 0; ph = 0;
            end else begin
                if (ph) chk("idle_after_handshake", busy_o, 0);
                if (res_valid_o && pv && !pr) begin
                    chk("hold_delay", res_delay_o, pd);
                    chk("hold_timeout", res_timeout_o, pt);
                end
                if (res_valid_o === 1'b1 && res_ready_i) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got delay %0d want none", res_delay_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_delay", res_delay_o, e.dly);
                        chk("res_timeout", res_timeout_o, e.tmo);
                    end
                end
                ph = (res_valid_o === 1'b1) && res_ready_i;
                pv = (res_valid_o === 1'b1);
                pr = res_ready_i;
                pd = res_delay_o;
                pt = res_timeout_o;
            end
        end
    end

    // gap: response edge offset from the stimulus edge (-1 = never); wg: wrong-polarity
    // response edge offset (-1 = none); wstim: precede with a wrong-polarity stimulus edge.
    task automatic run_meas(input bit sel, input int gap, input int wg, input bit wstim,
                            input bit stray, input bit hold);
        bit   e;
        int   dly, to, last, n, saved;
        int   tl[$];
        bit   ll[$];
        res_t r;
        e   = sel ^ INV;
        dly = TMO;
        to  = 1;
        if (wg >= 0) begin tl.push_back(wg); ll.push_back(!e); end
        if (gap >= 0) begin tl.push_back(gap); ll.push_back(e); end
        foreach (tl[i]) begin
            if (to == 1 && ll[i] == e && tl[i] <= TMO) begin
                dly = tl[i];
                to  = 0;
            end
        end
        saved = ready_mode;
        if (hold) ready_mode = 2;
        r.dly = dly;
        r.tmo = to;
        exp_q.push_back(r);

        tick();
        stim_i = wstim ? sel : !sel;
        resp_i = (wg >= 0) ? e : !e;
        tick();
        tick();
        arm_i = 1'b1;
        edge_sel_i = sel;
        tick();
        arm_i = 1'b0;
        edge_sel_i = 1'($urandom_range(0, 1));
        chk("busy_after_arm", busy_o, 1);
        if (wstim) begin
            stim_i = !sel;
            tick();
        end
        last = TMO + 2;
        if (gap + 2 > last) last = gap + 2;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) stim_i = sel;
            if (k == wg) resp_i = !e;
            if (k == gap) resp_i = e;
            arm_i = stray && (k == 1);
            tick();
        end
        arm_i = 1'b0;
        if (hold) begin
            chk("valid_waiting", res_valid_o, 1);
            arm_i = 1'b1;
            edge_sel_i = sel;
            tick();
            arm_i = 1'b0;
            repeat (3) tick();
            chk("valid_still_held", res_valid_o, 1);
            ready_mode = 1;
        end
        n = 0;
        while (busy_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (busy_o !== 1'b0) chk("busy_release_timeout", 1, 0);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("rearm_ignored", busy_o, 0);
            end
        end
        ready_mode = saved;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        int g, w;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_delay", res_delay_o, 0);
        chk("rst_timeout", res_timeout_o, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        ready_mode = 0;
        run_meas(1'b0, 5, -1, 1'b0, 1'b0, 1'b0);
        run_meas(1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
        run_meas(1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
        run_meas(1'b1, -1, -1, 1'b0, 1'b0, 1'b1);

        // Reset while measuring.
        tick();
        stim_i = 1'b1;
        resp_i = 1'b0;
        tick();
        tick();
        arm_i = 1'b1;
        edge_sel_i = 1'b0;
        tick();
        arm_i = 1'b0;
        stim_i = 1'b0;
        repeat (3) tick();
        chk("busy_in_measure", busy_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", res_valid_o, 0);
        chk("midrst_delay", res_delay_o, 0);
        chk("midrst_timeout", res_timeout_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_meas(1'b0, 4, -1, 1'b0, 1'b0, 1'b0);

        ready_mode = 1;
        run_meas(1'b1, 3, -1, 1'b0, 1'b0, 1'b0);
        run_meas(1'b0, 11, -1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            g = $urandom_range(0, 26);
            w = (g > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, g - 1) : -1;
            ready_mode = $urandom_range(0, 1);
            run_meas(s, g, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
